// File: rtl/pa_ifu_sram_ecc_ctrl.sv
// SECDED access controller for the IFU 512x39 single-port SRAM: zero-fill sweep
// after reset, Hamming encode on write, decode/correct on read, scrub write-back.
module pa_ifu_sram_ecc_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int CODE_WIDTH = 39
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  req_vld,
  input  logic                  req_wen,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_rdy,
  output logic                  rsp_vld,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_serr,
  output logic                  rsp_derr,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [CODE_WIDTH-1:0] sram_wen,
  output logic [CODE_WIDTH-1:0] sram_d,
  input  logic [CODE_WIDTH-1:0] sram_q
);

  localparam int CHK_WIDTH = CODE_WIDTH - DATA_WIDTH - 1;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  // Hamming position of data bit idx: the idx-th non-power-of-two position from 3 up.
  function automatic logic [CHK_WIDTH-1:0] dpos(input int idx);
    int cnt;
    logic [CHK_WIDTH-1:0] r;
    cnt = 0;
    r   = '0;
    for (int p = 1; p < CODE_WIDTH; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) r = CHK_WIDTH'(p);
        cnt++;
      end
    end
    return r;
  endfunction

  function automatic logic [CHK_WIDTH-1:0] enc_chk(input logic [DATA_WIDTH-1:0] d);
    logic [CHK_WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (d[i]) c = c ^ dpos(i);
    end
    return c;
  endfunction

  function automatic logic [CODE_WIDTH-1:0] encode(input logic [DATA_WIDTH-1:0] d);
    logic [CHK_WIDTH-1:0] c;
    c = enc_chk(d);
    return {^{c, d}, c, d};
  endfunction

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    init_done_q, init_done_d;
  logic                    rd_vld_q, rd_vld_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic                    scrub_pending_q, scrub_pending_d;
  logic [ADDR_WIDTH-1:0]   scrub_addr_q, scrub_addr_d;
  logic [CODE_WIDTH-1:0]   scrub_cw_q, scrub_cw_d;
  logic                    rsp_vld_q, rsp_vld_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_serr_q, rsp_serr_d;
  logic                    rsp_derr_q, rsp_derr_d;

  logic [CHK_WIDTH-1:0]    syn;
  logic                    pe;
  logic [DATA_WIDTH-1:0]   flip;
  logic [DATA_WIDTH-1:0]   dec_data;
  logic                    req_acc;
  logic                    wr_hit;

  assign syn      = enc_chk(sram_q[DATA_WIDTH-1:0]) ^ sram_q[CODE_WIDTH-2:DATA_WIDTH];
  assign pe       = ^sram_q;
  assign dec_data = sram_q[DATA_WIDTH-1:0] ^ flip;

  // Only data positions are corrected; a flipped check or parity bit leaves data intact.
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_flip
    assign flip[gi] = pe & (syn == dpos(gi));
  end

  assign req_rdy  = init_done_q & ~scrub_pending_q;
  assign req_acc  = req_vld & req_rdy;
  assign wr_hit   = req_acc & req_wen & (req_addr == rd_addr_q);
  assign sram_wen = '0;

  assign rsp_vld   = rsp_vld_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_serr  = rsp_serr_q;
  assign rsp_derr  = rsp_derr_q;
  assign init_done = init_done_q;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    init_done_d     = init_done_q;
    rd_vld_d        = 1'b0;
    rd_addr_d       = rd_addr_q;
    scrub_pending_d = 1'b0;
    scrub_addr_d    = scrub_addr_q;
    scrub_cw_d      = scrub_cw_q;
    rsp_vld_d       = rd_vld_q;
    rsp_rdata_d     = rsp_rdata_q;
    rsp_serr_d      = 1'b0;
    rsp_derr_d      = 1'b0;
    sram_cen        = 1'b1;
    sram_gwen       = 1'b1;
    sram_a          = '0;
    sram_d          = '0;

    if (state_q == ST_INIT) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_a    = cnt_q;
      cnt_d     = cnt_q + 1'b1;
      if (cnt_q == '1) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end
    end else if (scrub_pending_q) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_a    = scrub_addr_q;
      sram_d    = scrub_cw_q;
    end else if (req_acc) begin
      sram_cen  = 1'b0;
      sram_gwen = ~req_wen;
      sram_a    = req_addr;
      sram_d    = req_wen ? encode(req_wdata) : '0;
      rd_vld_d  = ~req_wen;
      rd_addr_d = req_addr;
    end

    if (rd_vld_q) begin
      rsp_rdata_d = dec_data;
      rsp_serr_d  = pe;
      rsp_derr_d  = ~pe & (syn != '0);
      // A write to the same address in this cycle supersedes the scrub.
      if (pe && !wr_hit) begin
        scrub_pending_d = 1'b1;
        scrub_addr_d    = rd_addr_q;
        scrub_cw_d      = encode(dec_data);
      end
    end

    if (!cpurst_b) begin
      sram_cen  = 1'b1;
      sram_gwen = 1'b1;
      sram_a    = '0;
      sram_d    = '0;
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q         <= ST_INIT;
      cnt_q           <= '0;
      init_done_q     <= 1'b0;
      rd_vld_q        <= 1'b0;
      rd_addr_q       <= '0;
      scrub_pending_q <= 1'b0;
      scrub_addr_q    <= '0;
      scrub_cw_q      <= '0;
      rsp_vld_q       <= 1'b0;
      rsp_rdata_q     <= '0;
      rsp_serr_q      <= 1'b0;
      rsp_derr_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      init_done_q     <= init_done_d;
      rd_vld_q        <= rd_vld_d;
      rd_addr_q       <= rd_addr_d;
      scrub_pending_q <= scrub_pending_d;
      scrub_addr_q    <= scrub_addr_d;
      scrub_cw_q      <= scrub_cw_d;
      rsp_vld_q       <= rsp_vld_d;
      rsp_rdata_q     <= rsp_rdata_d;
      rsp_serr_q      <= rsp_serr_d;
      rsp_derr_q      <= rsp_derr_d;
    end
  end

endmodule

// File: tb/tb_pa_ifu_sram_ecc_ctrl.sv
// Bench for pa_ifu_sram_ecc_ctrl: behavioural SRAM with Q-side fault injection,
// table-driven write/read vectors, response scoreboard and hand-written corner cases.
module tb_pa_ifu_sram_ecc_ctrl;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_vld, req_wen, req_rdy;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_vld, rsp_serr, rsp_derr, init_done;
  logic [31:0] rsp_rdata;
  logic [8:0]  sram_a;
  logic        sram_cen, sram_gwen;
  logic [38:0] sram_wen, sram_d, sram_q;

  logic [38:0] mem [512];
  logic [38:0] q_raw = '0;
  logic [38:0] q_flip = '0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rsp_cnt = 0;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        serr;
    logic        derr;
  } rsp_t;
  rsp_t sb[$];
  rsp_t e;

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [38:0] flip;
    logic        serr;
    logic        derr;
    logic        scrub;
    logic [31:0] exp_rdata;
    logic [38:0] exp_cw;
  } vec_t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!sram_cen && !sram_gwen) mem[sram_a] <= sram_d;
    if (!sram_cen && sram_gwen) q_raw <= mem[sram_a];
  end
  assign sram_q = q_raw ^ q_flip;

  pa_ifu_sram_ecc_ctrl dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .req_vld        (req_vld),
    .req_wen        (req_wen),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_rdy        (req_rdy),
    .rsp_vld        (rsp_vld),
    .rsp_rdata      (rsp_rdata),
    .rsp_serr       (rsp_serr),
    .rsp_derr       (rsp_derr),
    .init_done      (init_done),
    .sram_a         (sram_a),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  // Reference encoder built from the positional Hamming definition.
  function automatic logic [38:0] ref_enc(input logic [31:0] d);
    logic [38:0] h;
    logic [5:0]  c;
    int          di;
    h  = '0;
    di = 0;
    for (int p = 1; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        h[p] = d[di];
        di++;
      end
    end
    for (int k = 0; k < 6; k++) begin
      c[k] = 1'b0;
      for (int p = 1; p < 39; p++) begin
        if (((p >> k) & 1) == 1 && (p & (p - 1)) != 0) c[k] = c[k] ^ h[p];
      end
    end
    return {^{c, d}, c, d};
  endfunction

  function automatic vec_t mk(input logic [8:0] a, input logic [31:0] d,
                              input logic [38:0] f, input logic s, input logic x);
    vec_t v;
    v.addr      = a;
    v.wdata     = d;
    v.flip      = f;
    v.serr      = s;
    v.derr      = x;
    v.scrub     = s;
    v.exp_rdata = x ? (d ^ f[31:0]) : d;
    v.exp_cw    = ref_enc(d);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_vld) begin
        rsp_cnt++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected: got rdata=0x%0h at cycle %0d want no response", rsp_rdata, cyc);
        end else begin
          e = sb.pop_front();
          $display("rsp cyc=%0d rdata=0x%08h serr=%0b derr=%0b", cyc, rsp_rdata, rsp_serr, rsp_derr);
          chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          chk("rsp_serr", 64'(rsp_serr), 64'(e.serr));
          chk("rsp_derr", 64'(rsp_derr), 64'(e.derr));
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        total++;
        bad++;
        $display("FAIL rsp_missing: got no rsp_vld at cycle %0d want rdata=0x%0h", cyc, e.rdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_vld = 1'b0;
    req_wen = 1'b0;
  endtask

  task automatic drive_wr(input logic [8:0] a, input logic [31:0] d);
    req_vld   = 1'b1;
    req_wen   = 1'b1;
    req_addr  = a;
    req_wdata = d;
    $display("wr  cyc=%0d addr=%0d data=0x%08h", cyc, a, d);
  endtask

  task automatic drive_rd(input logic [8:0] a, input logic [31:0] d, input logic s, input logic x);
    rsp_t r;
    req_vld = 1'b1;
    req_wen = 1'b0;
    req_addr = a;
    r.cyc   = cyc + 2;
    r.rdata = d;
    r.serr  = s;
    r.derr  = x;
    sb.push_back(r);
    $display("rd  cyc=%0d addr=%0d", cyc, a);
  endtask

  // Entered just after reset release; leaves the bench in cycle 512 at a drive point.
  task automatic check_sweep(input string tag);
    int errs;
    errs = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_a !== i[8:0] || sram_d !== 39'd0 ||
          req_rdy !== 1'b0 || init_done !== 1'b0) errs++;
      @(posedge clk);
    end
    #1;
    chk({tag, "_bad_cycles"}, 64'(errs), 64'd0);
    chk({tag, "_init_done"}, 64'(init_done), 64'd1);
    chk({tag, "_req_rdy"}, 64'(req_rdy), 64'd1);
    chk({tag, "_idle_cen"}, 64'(sram_cen), 64'd1);
  endtask

  initial begin
    vec_t vt [10];
    int   rc0;

    vt[0] = mk(9'd5,   32'h0000_0001, 39'd0,                       1'b0, 1'b0);
    vt[0].exp_cw = 39'h43_0000_0001;
    vt[1] = mk(9'd5,   32'h0000_0001, 39'd1,                       1'b1, 1'b0);
    vt[2] = mk(9'd5,   32'h0000_0001, 39'd3,                       1'b0, 1'b1);
    vt[3] = mk(9'd100, 32'hDEAD_BEEF, 39'd1 << 17,                 1'b1, 1'b0);
    vt[4] = mk(9'd200, 32'h1234_5678, 39'd1 << 35,                 1'b1, 1'b0);
    vt[5] = mk(9'd511, 32'hFFFF_FFFF, 39'd1 << 38,                 1'b1, 1'b0);
    vt[6] = mk(9'd0,   32'hA5A5_A5A5, (39'd1 << 3) | (39'd1 << 20), 1'b0, 1'b1);
    vt[7] = mk(9'd300, 32'h8000_0000, 39'd1 << 31,                 1'b1, 1'b0);
    vt[8] = mk(9'd7,   32'h0000_0000, (39'd1 << 38) | (39'd1 << 5), 1'b0, 1'b1);
    vt[9] = mk(9'd42,  32'h0F0F_0F0F, 39'd1 << 32,                 1'b1, 1'b0);

    idle();
    req_addr  = '0;
    req_wdata = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cen", 64'(sram_cen), 64'd1);
    chk("rst_gwen", 64'(sram_gwen), 64'd1);
    chk("rst_a", 64'(sram_a), 64'd0);
    chk("rst_d", 64'(sram_d), 64'd0);
    chk("rst_wen", 64'(sram_wen), 64'd0);
    chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_req_rdy", 64'(req_rdy), 64'd0);
    rst_n = 1'b1;
    check_sweep("sweep");

    for (int v = 0; v < 10; v++) begin
      drive_wr(vt[v].addr, vt[v].wdata);
      @(negedge clk);
      chk("wr_cen", 64'(sram_cen), 64'd0);
      chk("wr_gwen", 64'(sram_gwen), 64'd0);
      chk("wr_a", 64'(sram_a), 64'(vt[v].addr));
      chk("wr_d", 64'(sram_d), 64'(vt[v].exp_cw));
      chk("wr_wen", 64'(sram_wen), 64'd0);
      tick();
      drive_rd(vt[v].addr, vt[v].exp_rdata, vt[v].serr, vt[v].derr);
      @(negedge clk);
      chk("rd_cen", 64'(sram_cen), 64'd0);
      chk("rd_gwen", 64'(sram_gwen), 64'd1);
      chk("rd_a", 64'(sram_a), 64'(vt[v].addr));
      tick();
      idle();
      q_flip = vt[v].flip;
      tick();
      q_flip = '0;
      @(negedge clk);
      if (vt[v].scrub) begin
        chk("scrub_cen", 64'(sram_cen), 64'd0);
        chk("scrub_gwen", 64'(sram_gwen), 64'd0);
        chk("scrub_a", 64'(sram_a), 64'(vt[v].addr));
        chk("scrub_d", 64'(sram_d), 64'(vt[v].exp_cw));
        chk("scrub_req_rdy", 64'(req_rdy), 64'd0);
      end else begin
        chk("noscrub_cen", 64'(sram_cen), 64'd1);
        chk("noscrub_req_rdy", 64'(req_rdy), 64'd1);
      end
      tick();
    end

    // Read A, then overwrite A before the scrub would issue: scrub must be dropped.
    drive_wr(9'd50, 32'h1357_9BDF);
    tick();
    drive_rd(9'd50, 32'h1357_9BDF, 1'b1, 1'b0);
    tick();
    drive_wr(9'd50, 32'h2468_ACE0);
    q_flip = 39'd1 << 2;
    @(negedge clk);
    chk("cancel_wr_rdy", 64'(req_rdy), 64'd1);
    chk("cancel_wr_d", 64'(sram_d), 64'(ref_enc(32'h2468_ACE0)));
    tick();
    idle();
    q_flip = '0;
    @(negedge clk);
    chk("cancel_no_scrub_cen", 64'(sram_cen), 64'd1);
    chk("cancel_req_rdy", 64'(req_rdy), 64'd1);
    tick();
    drive_rd(9'd50, 32'h2468_ACE0, 1'b0, 1'b0);
    tick();
    idle();
    repeat (3) tick();

    // Back-to-back reads of 0..15.
    for (int i = 0; i < 16; i++) begin
      drive_wr(i[8:0], 32'hC0DE_0000 + i * 32'h0001_0111);
      tick();
    end
    rc0 = rsp_cnt;
    for (int i = 0; i < 16; i++) begin
      drive_rd(i[8:0], 32'hC0DE_0000 + i * 32'h0001_0111, 1'b0, 1'b0);
      tick();
    end
    idle();
    repeat (3) tick();
    chk("b2b_rsp_count", 64'(rsp_cnt - rc0), 64'd16);

    // Reset with responses in flight.
    for (int i = 0; i < 4; i++) begin
      drive_rd(i[8:0], 32'hC0DE_0000 + i * 32'h0001_0111, 1'b0, 1'b0);
      tick();
    end
    idle();
    chk("pre_reset_rsp_vld", 64'(rsp_vld), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("midrst_cen", 64'(sram_cen), 64'd1);
    chk("midrst_gwen", 64'(sram_gwen), 64'd1);
    chk("midrst_init_done", 64'(init_done), 64'd0);
    chk("midrst_req_rdy", 64'(req_rdy), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_sweep("resweep");

    drive_rd(9'd5, 32'h0000_0000, 1'b0, 1'b0);
    tick();
    idle();
    repeat (3) tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
